// File: rtl/controller_uart_ctrl_pio.sv
// rtl/controller_uart_ctrl_pio.sv - Avalon-MM PIO output port with set/clear/toggle and self-clearing strobe bits
module controller_uart_ctrl_pio #(
    parameter int          WIDTH        = 2,
    parameter logic [31:0] RESET_VALUE  = 32'd0,
    parameter logic [31:0] PULSE_MASK   = 32'd0,
    parameter int          PULSE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             out_changed
);

    localparam int               CW        = $clog2(PULSE_CYCLES + 1);
    localparam logic [CW-1:0]    LP_RELOAD = CW'(PULSE_CYCLES);
    localparam logic [CW-1:0]    LP_ONE    = CW'(1);
    localparam logic [WIDTH-1:0] LP_RST    = RESET_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] LP_STB    = PULSE_MASK[WIDTH-1:0];

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_prev;
    logic             r_changed;
    logic [CW-1:0]    r_cnt      [WIDTH];

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_hit;
    logic [WIDTH-1:0] w_wval;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_busy;
    logic [CW-1:0]    w_cnt_next [WIDTH];

    assign w_wr = chipselect & ~write_n;

    // w_hit marks the bits a write actually defines; DATA defines every bit
    always_comb begin
        w_wd = writedata[WIDTH-1:0];
        case (address)
            2'd0:    w_wval = w_wd;
            2'd1:    w_wval = r_out | w_wd;
            2'd2:    w_wval = r_out & ~w_wd;
            default: w_wval = r_out ^ w_wd;
        endcase
        w_hit = (address == 2'd0) ? '1 : w_wd;
        if (!w_wr) begin
            w_hit = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_next[i]     = r_out[i];
            w_cnt_next[i] = '0;
            w_busy[i]     = 1'b0;
            if (LP_STB[i]) begin
                w_busy[i]     = (r_cnt[i] != '0);
                w_cnt_next[i] = r_cnt[i];
                if (w_hit[i]) begin
                    // a write beats a same-edge expiry
                    w_next[i]     = w_wval[i];
                    w_cnt_next[i] = w_wval[i] ? LP_RELOAD : '0;
                end else if (r_cnt[i] != '0) begin
                    w_cnt_next[i] = r_cnt[i] - LP_ONE;
                    if (r_cnt[i] == LP_ONE) begin
                        w_next[i] = 1'b0;
                    end
                end
            end else if (w_hit[i]) begin
                w_next[i] = w_wval[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out     <= LP_RST;
            r_prev    <= LP_RST;
            r_changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_out     <= w_next;
            r_prev    <= r_out;
            r_changed <= (r_out != r_prev);
            r_cnt     <= w_cnt_next;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = r_out;
            2'd1:    readdata[WIDTH-1:0] = w_busy;
            default: readdata = '0;
        endcase
    end

    generate
        if (WIDTH < 32) begin : g_unused
            logic w_unused_wd;
            assign w_unused_wd = ^writedata[31:WIDTH];
        end
    endgenerate

    assign out_port    = r_out;
    assign out_changed = r_changed;

endmodule

// File: doc/controller_uart_ctrl_pio.md
CONTROLLER_UART_CTRL_PIO -- requirements
Module: controller_uart_ctrl_pio

Interface
REQ-001 The module SHALL have parameter WIDTH, default 2: number of output control bits, legal range 1..32.
REQ-002 The module SHALL have parameter RESET_VALUE, default 0: value loaded into out_port at reset; bits at WIDTH and above are ignored.
REQ-003 The module SHALL have parameter PULSE_MASK, default 0: a 1 in bit i makes out_port[i] self-clearing (strobe bit).
REQ-004 The module SHALL have parameter PULSE_CYCLES, default 16: strobe high time in clk cycles, legal range 1..65535.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-006 Port reset, input, 1 bit: reset SHALL be synchronous and active-high.
REQ-007 Port address, input, 2 bits: Avalon-MM word address.
REQ-008 Port chipselect, input, 1 bit: slave select.
REQ-009 Port write_n, input, 1 bit: active-low write strobe.
REQ-010 Port writedata, input, 32 bits: write data.
REQ-011 Port readdata, output, 32 bits: read data, combinational, zero wait states.
REQ-012 Port out_port, output, WIDTH bits: registered control outputs.
REQ-013 Port out_changed, output, 1 bit: registered; high for one cycle after any cycle in which out_port changed value.

Function
REQ-014 A write SHALL be chipselect=1 and write_n=0 at a rising clk edge; only writedata[WIDTH-1:0] SHALL be used.
REQ-015 Address 0 (DATA) SHALL load out_port with writedata, and SHALL read back as out_port zero-extended to 32 bits.
REQ-016 Address 1 (SET) SHALL set out_port bits where writedata is 1, and SHALL read back as the BUSY vector (bit i = strobe counter i nonzero).
REQ-017 Address 2 (CLEAR) SHALL clear out_port bits where writedata is 1, and SHALL read back as 0.
REQ-018 Address 3 (TOGGLE) SHALL invert out_port bits where writedata is 1, and SHALL read back as 0.
REQ-019 A write SHALL take effect on out_port in the cycle immediately after the write edge (latency 1).
REQ-020 Readdata bits above WIDTH SHALL always be 0.
REQ-021 Each PULSE_MASK bit i SHALL have a down-counter with width ceil(log2(PULSE_CYCLES+1)).
REQ-022 Any write that leaves out_port[i]=1 for a strobe bit SHALL reload counter i with PULSE_CYCLES. This applies to a DATA write with bit 1, a SET write with bit 1, and a TOGGLE write from 0 to 1. A reload re-arms an active strobe.
REQ-023 While counter i is nonzero and no reload occurs, it SHALL decrement by 1 per cycle; the edge that takes it from 1 to 0 SHALL also clear out_port[i].
REQ-024 Strobe duration rule: a strobe bit SHALL be high for exactly PULSE_CYCLES cycles after an un-retriggered set.
REQ-025 Any write that leaves out_port[i]=0 for a strobe bit SHALL zero counter i immediately. This applies to a CLEAR write, a DATA write with bit 0, and a TOGGLE write from 1 to 0.
REQ-026 Simultaneous expiry and write on the same edge: the write result SHALL win. A set or reload gives bit 1 with the counter reloaded; a clear gives bit 0 with the counter at 0.
REQ-027 Non-strobe bits SHALL hold their value indefinitely between writes; their BUSY bits SHALL read 0.
REQ-028 Reads SHALL have no side effects.
REQ-029 Writes with chipselect=0 or write_n=1 SHALL change nothing.
REQ-030 out_changed SHALL be 1 in cycle n+1 if and only if out_port in cycle n differs from cycle n-1. This includes changes caused by strobe expiry, and excludes writes that produce no value change.

Reset
REQ-031 When reset=1 at a clk edge, out_port SHALL become RESET_VALUE[WIDTH-1:0], all strobe counters SHALL become 0, and out_changed SHALL become 0.
REQ-032 Reset SHALL override any concurrent write; a strobe in progress SHALL be abandoned with no delayed clear.
REQ-033 Strobe bits set to 1 by RESET_VALUE SHALL not self-clear until written (counter 0 at reset).
REQ-034 The first cycle after reset deasserts SHALL NOT produce out_changed.

Verification
REQ-035 WIDTH=2, RESET_VALUE=2: apply reset, write DATA=3 -> out_port=2 during reset; out_port=3 one cycle after the write; reading address 0 returns 0x00000003; out_changed is 1 for one cycle.
REQ-036 WIDTH=8, starting from DATA=0x0F: write SET=0xF0, then CLEAR=0x81, then TOGGLE=0xFF -> out_port goes 0xFF, then 0x7E, then 0x81.
REQ-037 PULSE_MASK=1, PULSE_CYCLES=4: write SET=1 -> out_port[0] is high exactly 4 cycles; BUSY reads 1 during that time and 0 afterwards; out_changed pulses at the rise and at the fall.
REQ-038 PULSE_MASK=1, PULSE_CYCLES=4: write SET=1, then write SET=1 again 3 cycles later -> bit stays high 7 cycles in total. Repeat with a CLEAR=1 on the expiry edge -> bit 0, counter 0.
REQ-039 Strobe active with counter at 2: assert reset one cycle -> out_port=RESET_VALUE, BUSY=0, no later clear event.
REQ-040 Writedata=0xFFFFFFFF to DATA with WIDTH=2 -> readdata=0x00000003; address 2 and address 3 read 0; a write with chipselect=0 leaves out_port unchanged.
